// File: rtl/adc_spi_responder_if.sv
// Serial link between an ADC controller and the touch-screen ADC responder.
// The master drives chip select, serial clock and command data; the slave answers.
interface adc_spi_responder_if;
  logic iADC_CS_n;
  logic iADC_DCLK;
  logic iADC_DIN;
  logic oADC_DOUT;
  logic oADC_BUSY;
  logic oADC_PENIRQ_n;

  modport master (
    output iADC_CS_n, iADC_DCLK, iADC_DIN,
    input  oADC_DOUT, oADC_BUSY, oADC_PENIRQ_n
  );

  modport slave (
    input  iADC_CS_n, iADC_DCLK, iADC_DIN,
    output oADC_DOUT, oADC_BUSY, oADC_PENIRQ_n
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Touch-screen ADC responder: decodes a serial command, returns a latched X/Y value.
// Optional macro TOUCH_FILTER_EN adds a FILTER_LEN-cycle stability filter on iTOUCH.
module adc_spi_responder #(
  parameter int FILTER_LEN = 16
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  adc_spi_responder_if.slave        adc,
  input  logic [11:0]               iX_COORD,
  input  logic [11:0]               iY_COORD,
  input  logic                      iTOUCH
);

  typedef enum logic [1:0] {IDLE, CMD, BUSY, DATA} state_t;

  if (FILTER_LEN < 1) begin : g_len_check
    $error("FILTER_LEN must be at least 1");
  end

  // Synchronizers for the asynchronous serial link and the touch input
  logic [1:0] cs_sync, dclk_sync, din_sync, touch_sync;
  logic       dclk_prev;
  logic       cs_n_s, din_s, touch_s, dclk_rise, dclk_fall, touch_f;

  assign cs_n_s    = cs_sync[1];
  assign din_s     = din_sync[1];
  assign touch_s   = touch_sync[1];
  assign dclk_rise =  dclk_sync[1] & ~dclk_prev;
  assign dclk_fall = ~dclk_sync[1] &  dclk_prev;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cs_sync    <= '0;
      dclk_sync  <= '0;
      din_sync   <= '0;
      touch_sync <= '0;
      dclk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value, forming a true 2-stage chain.
      cs_sync    <= {cs_sync[0],    adc.iADC_CS_n};
      dclk_sync  <= {dclk_sync[0],  adc.iADC_DCLK};
      din_sync   <= {din_sync[0],   adc.iADC_DIN};
      touch_sync <= {touch_sync[0], iTOUCH};
      dclk_prev  <= dclk_sync[1];
    end
  end

`ifdef TOUCH_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  logic [CNT_W-1:0] filt_cnt_q;
  logic             touch_f_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      filt_cnt_q <= '0;
      touch_f_q  <= 1'b0;
    end else if (touch_s == touch_f_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      touch_f_q  <= touch_s;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign touch_f = touch_f_q;
`else
  assign touch_f = touch_s;
`endif

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  cmd_sr_q, cmd_sr_d;
  logic [11:0] word_q, word_d;
  logic [3:0]  bits_left_q, bits_left_d;
  logic        mode_q, mode_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        pen_en_q, pen_en_d;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      word_q      <= '0;
      bits_left_q <= '0;
      mode_q      <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      pen_en_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      word_q      <= word_d;
      bits_left_q <= bits_left_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      pen_en_q    <= pen_en_d;
    end
  end

  always_comb begin
    // NOTE: every output takes its hold value first so no path leaves a latch behind.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    word_d      = word_q;
    bits_left_d = bits_left_q;
    mode_d      = mode_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    pen_en_d    = pen_en_q;

    if (cs_n_s) begin
      state_d   = IDLE;
      dout_d    = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      cmd_sr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dclk_rise && din_s) begin
            state_d   = CMD;
            bit_cnt_d = 3'd1;
            cmd_sr_d  = '0;
          end
        end
        CMD: begin
          if (dclk_rise) begin
            cmd_sr_d  = {cmd_sr_q[4:0], din_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            // Rise 8: cmd_sr_q holds A2..PD1 and din_s is PD0
            if (bit_cnt_q == 3'd7) begin
              state_d  = BUSY;
              mode_d   = cmd_sr_q[2];
              pen_en_d = ({cmd_sr_q[0], din_s} == 2'b00);
              case (cmd_sr_q[5:3])
                3'b101:  word_d = iX_COORD;
                3'b001:  word_d = iY_COORD;
                default: word_d = '0;
              endcase
            end
          end
        end
        BUSY: begin
          if (dclk_fall) begin
            if (!busy_q) begin
              busy_d = 1'b1;
            end else begin
              busy_d      = 1'b0;
              dout_d      = word_q[11];
              word_d      = {word_q[10:0], 1'b0};
              bits_left_d = mode_q ? 4'd7 : 4'd11;
              state_d     = DATA;
            end
          end
        end
        DATA: begin
          if (dclk_fall) begin
            if (bits_left_q == 4'd0) begin
              dout_d  = 1'b0;
              state_d = IDLE;
            end else begin
              dout_d      = word_q[11];
              word_d      = {word_q[10:0], 1'b0};
              bits_left_d = bits_left_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign adc.oADC_DOUT     = dout_q;
  assign adc.oADC_BUSY     = busy_q;
  assign adc.oADC_PENIRQ_n = ~(pen_en_q && (state_q == IDLE) && touch_f);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: directed frame table, random frames
// against a word-level model, plus abort, reset, PENIRQ and touch-filter sequences.
module tb_adc_spi_responder;

  typedef struct {
    logic [7:0]  cmd;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] exp_word;
    int          bits;
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] x_coord, y_coord;
  logic        touch;

  adc_spi_responder_if adc ();

  adc_spi_responder #(.FILTER_LEN(16)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .adc      (adc.slave),
    .iX_COORD (x_coord),
    .iY_COORD (y_coord),
    .iTOUCH   (touch)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;
  bit pen_en_m = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which value a command reports and how many bits it returns
  function automatic void model_frame(input logic [7:0] cmd, input logic [11:0] xv,
                                      input logic [11:0] yv, output logic [11:0] word,
                                      output int nbits);
    case (cmd[6:4])
      3'b101:  word = xv;
      3'b001:  word = yv;
      default: word = 12'h000;
    endcase
    nbits = cmd[3] ? 8 : 12;
  endfunction

  function automatic logic exp_dout(input logic [11:0] word, input int nbits, input int fall);
    if (fall >= 9 && fall < 9 + nbits) return word[11 - (fall - 9)];
    return 1'b0;
  endfunction

  // One 24-DCLK frame; optional abort by CS_n or reset after the given fall
  task automatic run_frame(input vec_t v, input int abort_at, input int reset_at);
    logic exp_pen;
    x_coord = v.x;
    y_coord = v.y;
    adc.iADC_CS_n = 1'b0;
    adc.iADC_DCLK = 1'b0;
    adc.iADC_DIN  = 1'b0;
    #60;
    for (int i = 1; i <= 24; i++) begin
      if (i <= 8)               adc.iADC_DIN = v.cmd[8 - i];
      else if (i <= 8 + v.bits) adc.iADC_DIN = 1'($urandom_range(0, 1));
      else                      adc.iADC_DIN = 1'b0;
      #30 adc.iADC_DCLK = 1'b1;
      #60 adc.iADC_DCLK = 1'b0;
      #38;
      if (i == 8) begin
        pen_en_m = (v.cmd[1:0] == 2'b00);
        x_coord  = 12'($urandom);
        y_coord  = 12'($urandom);
      end
      exp_pen = (i <= 8 + v.bits) ? 1'b1 : !(pen_en_m && touch);
      check($sformatf("dout cmd=%0h fall=%0d", v.cmd, i), 32'(adc.oADC_DOUT),
            32'(exp_dout(v.exp_word, v.bits, i)));
      check($sformatf("busy cmd=%0h fall=%0d", v.cmd, i), 32'(adc.oADC_BUSY), 32'(i == 8));
      check($sformatf("penirq cmd=%0h fall=%0d", v.cmd, i), 32'(adc.oADC_PENIRQ_n), 32'(exp_pen));
      if (i == abort_at) begin
        #22 adc.iADC_CS_n = 1'b1;
        #38;
        check("abort dout", 32'(adc.oADC_DOUT), 32'd0);
        check("abort busy", 32'(adc.oADC_BUSY), 32'd0);
        #22;
        return;
      end
      if (i == reset_at) begin
        iRST = 1'b1;
        #1;
        check("reset dout", 32'(adc.oADC_DOUT), 32'd0);
        check("reset busy", 32'(adc.oADC_BUSY), 32'd0);
        check("reset penirq", 32'(adc.oADC_PENIRQ_n), 32'd1);
        pen_en_m = 1'b1;
        #20 iRST = 1'b0;
        adc.iADC_CS_n = 1'b1;
        #59;
        return;
      end
      #22;
    end
    adc.iADC_CS_n = 1'b1;
    adc.iADC_DIN  = 1'b0;
    #100;
  endtask

  vec_t table_v[5];
  vec_t xread;
  vec_t rv;
  bit   seen_low;

  initial begin
    table_v[0] = '{cmd: 8'hD0, x: 12'hA5C, y: 12'h3F1, exp_word: 12'hA5C, bits: 12};
    table_v[1] = '{cmd: 8'h98, x: 12'hA5C, y: 12'h3F1, exp_word: 12'h3F1, bits: 8};
    table_v[2] = '{cmd: 8'h90, x: 12'h123, y: 12'h456, exp_word: 12'h456, bits: 12};
    table_v[3] = '{cmd: 8'hA4, x: 12'hFFF, y: 12'hFFF, exp_word: 12'h000, bits: 12};
    table_v[4] = '{cmd: 8'hD8, x: 12'h5A5, y: 12'h000, exp_word: 12'h5A5, bits: 8};
    xread      = table_v[0];

    iRST = 1'b1;
    adc.iADC_CS_n = 1'b1;
    adc.iADC_DCLK = 1'b0;
    adc.iADC_DIN  = 1'b0;
    touch   = 1'b0;
    x_coord = '0;
    y_coord = '0;
    #1;
    check("init dout", 32'(adc.oADC_DOUT), 32'd0);
    check("init busy", 32'(adc.oADC_BUSY), 32'd0);
    check("init penirq", 32'(adc.oADC_PENIRQ_n), 32'd1);
    #23 iRST = 1'b0;
    @(negedge iCLK);
    #100;

    for (int k = 0; k < 5; k++) run_frame(table_v[k], 0, 0);

    for (int k = 0; k < 8; k++) begin
      rv.cmd = {1'b1, 7'($urandom)};
      rv.x   = 12'($urandom);
      rv.y   = 12'($urandom);
      model_frame(rv.cmd, rv.x, rv.y, rv.exp_word, rv.bits);
      run_frame(rv, 0, 0);
    end

    // Abort by CS_n after fall 12, then a full read
    run_frame(xread, 12, 0);
    run_frame(xread, 0, 0);

    // Reset mid-frame, then a fresh read
    run_frame(xread, 0, 10);
    run_frame(xread, 0, 0);

    // PENIRQ gated by the enable from PD1/PD0
    touch = 1'b1;
    #300;
    run_frame(xread, 0, 0);
    check("penirq touch pd00", 32'(adc.oADC_PENIRQ_n), 32'd0);
    rv = '{cmd: 8'hD3, x: 12'h0F0, y: 12'h000, exp_word: 12'h0F0, bits: 12};
    run_frame(rv, 0, 0);
    check("penirq touch pd11", 32'(adc.oADC_PENIRQ_n), 32'd1);
    touch = 1'b0;
    #300;
    run_frame(xread, 0, 0);

`ifdef TOUCH_FILTER_EN
    seen_low = 1'b0;
    touch = 1'b1;
    repeat (10) @(negedge iCLK);
    touch = 1'b0;
    repeat (40) begin
      @(negedge iCLK);
      if (!adc.oADC_PENIRQ_n) seen_low = 1'b1;
    end
    check("filter short pulse", 32'(seen_low), 32'd0);
    seen_low = 1'b0;
    touch = 1'b1;
    repeat (20) begin
      @(negedge iCLK);
      if (!adc.oADC_PENIRQ_n) seen_low = 1'b1;
    end
    touch = 1'b0;
    repeat (10) begin
      @(negedge iCLK);
      if (!adc.oADC_PENIRQ_n) seen_low = 1'b1;
    end
    check("filter long pulse", 32'(seen_low), 32'd1);
    #400;
`else
    touch = 1'b1;
    repeat (4) @(negedge iCLK);
    check("touch follow high", 32'(adc.oADC_PENIRQ_n), 32'd0);
    touch = 1'b0;
    repeat (4) @(negedge iCLK);
    check("touch follow low", 32'(adc.oADC_PENIRQ_n), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 16, iCLK cycles iTOUCH must be stable before it is accepted (used only with TOUCH_FILTER_EN).
REQ-002 SHALL have port iCLK  input  1  system clock; the single clock for all logic.
REQ-003 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iADC_CS_n  input  1  chip select, active-low, asynchronous to iCLK.
REQ-005 SHALL have port iADC_DCLK  input  1  serial clock from the ADC controller, asynchronous to iCLK.
REQ-006 SHALL have port iADC_DIN  input  1  serial command data, sampled on DCLK rising edges.
REQ-007 SHALL have port oADC_DOUT  output  1  serial conversion result, updated after DCLK falling edges.
REQ-008 SHALL have port oADC_BUSY  output  1  conversion-busy indicator.
REQ-009 SHALL have port oADC_PENIRQ_n  output  1  pen interrupt, active-low.
REQ-010 SHALL have port iX_COORD  input  12  X value to report.
REQ-011 SHALL have port iY_COORD  input  12  Y value to report.
REQ-012 SHALL have port iTOUCH  input  1  pen down when high.

Function
REQ-013 SHALL pass iADC_CS_n, iADC_DCLK and iADC_DIN through 2-flop synchronizers and detect DCLK edges on the synchronized signal; DCLK high and low phases are at least 4 iCLK cycles each.
REQ-014 SHALL change outputs no later than 3 iCLK cycles after the DCLK edge that triggers the change.
REQ-015 SHALL implement states IDLE, CMD, BUSY, DATA.
REQ-016 IDLE: CS_n low and a DCLK rise with DIN=1 (start bit) -> CMD, with bit count 1.
REQ-017 CMD: shift DIN on rises 2..8 into a 7-bit command {A2,A1,A0,MODE,SER/DFR,PD1,PD0}; on rise 8 latch the command and the coordinate selected by it, then -> BUSY.
REQ-018 SHALL select the coordinate as follows: A2..A0=101 -> iX_COORD, 001 -> iY_COORD, any other code -> 12'h000.
REQ-019 BUSY: oADC_BUSY SHALL rise after DCLK fall 8 and clear after fall 9; fall 9 SHALL also drive result bit 11 onto oADC_DOUT and -> DATA.
REQ-020 DATA: each later fall SHALL shift out the next lower bit, MSB first: MODE=0 gives 12 bits (bit 0 after fall 20); MODE=1 gives bits 11..4 (last after fall 16).
REQ-021 The fall after the last data bit SHALL drive oADC_DOUT to 0 and -> IDLE; a start bit is accepted from the next rise.
REQ-022 SHALL hold oADC_DOUT at 0 in IDLE and CMD.
REQ-023 SHALL ignore DIN in BUSY and DATA.
REQ-024 Latched coordinates SHALL stay constant through a frame even if iX_COORD/iY_COORD change.
REQ-025 Synchronized CS_n high in any state SHALL force IDLE, oADC_DOUT=0 and oADC_BUSY=0 on the next iCLK; the partial command SHALL be discarded.
REQ-026 SHALL hold a PENIRQ-enable register, set to 1 at reset and loaded with (PD1,PD0)==00 when a command is latched.
REQ-027 oADC_PENIRQ_n SHALL be low only when the enable is 1, the state is IDLE, and the (filtered) touch is 1; otherwise it SHALL be high.

Reset
REQ-028 iRST high SHALL asynchronously force state IDLE, oADC_DOUT=0, oADC_BUSY=0, oADC_PENIRQ_n=1, PENIRQ-enable=1, all counters, shift registers, synchronizers and the filter to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release, a new start bit is required.

Configuration
REQ-030 With TOUCH_FILTER_EN defined, the filtered touch SHALL change only after iTOUCH has held a new value for FILTER_LEN consecutive iCLK cycles.
REQ-031 Without TOUCH_FILTER_EN, the filtered touch SHALL be iTOUCH through a 2-flop synchronizer only, and no filter counter SHALL be built.

Verification
REQ-032 Reset: assert iRST mid-frame -> DOUT=0, BUSY=0, PENIRQ_n=1 immediately; then a fresh command 0xD0 returns X correctly.
REQ-033 X read: iX_COORD=12'hA5C, command byte 0xD0 (start,101,MODE0,PD00), 24 DCLKs -> BUSY high between falls 8 and 9; DOUT=1010_0101_1100 on falls 9..20; 0 afterwards.
REQ-034 Y read 8-bit: iY_COORD=12'h3F1, command 0x98 -> DOUT=0011_1111 on falls 9..16; then 0.
REQ-035 Abort: raise CS_n after fall 12 of an X read -> DOUT=0 and BUSY=0 within 3 iCLK; the next 0xD0 frame returns the full value.
REQ-036 PENIRQ: iTOUCH=1 after command 0xD0 -> PENIRQ_n low in IDLE, high during the frame; after command 0xD3 (PD=11) -> PENIRQ_n stays high.
REQ-037 Filter (TOUCH_FILTER_EN, FILTER_LEN=16): 10-cycle iTOUCH pulse -> no PENIRQ_n change; 20-cycle pulse -> PENIRQ_n low.
